// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite engine slice.
// Holds the command opcode encodings, the engine FSM state type, a few
// 24-bit RGB colour constants used by the game path, and the default
// visible-screen dimensions.
package sprite_pkg;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'd0,
        OP_DRAW  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_HOME  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_RASTER,
        ST_FLUSH
    } state_e;

    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] ORANGE = 24'hFF8000;
    localparam logic [23:0] BROWN  = 24'h8B4513;

    localparam int DEFAULT_SCREEN_W = 160;
    localparam int DEFAULT_SCREEN_H = 120;

endpackage

// File: rtl/sprite_raster_walker.sv
// Walks one sprite box in raster order and produces registered plot pixels.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start                 load base position / channel / mode (command accepted)
//   active                advance one box offset per cycle (FSM in RASTER)
//   is_clear, chan        mode and sprite id captured on start
//   base_x, base_y        signed sprite position captured on start
//   lut_chan/ox/oy        colour lookup address (current offset)
//   lut_colour/transparent  lookup result for the current address
//   last                  current address is the final one in the box
//   pix_x/y/colour/plot   registered pixel, one cycle behind the address
module sprite_raster_walker
    import sprite_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int SPR_W    = 15,
    parameter int SPR_H    = 10,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 1,
    parameter int COLOUR_W = 24,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                active,
    input  logic                is_clear,
    input  logic [CW-1:0]       chan,
    input  logic signed [XW:0]  base_x,
    input  logic signed [YW:0]  base_y,
    output logic [CW-1:0]       lut_chan,
    output logic [4:0]          lut_ox,
    output logic [3:0]          lut_oy,
    input  logic [COLOUR_W-1:0] lut_colour,
    input  logic                lut_transparent,
    output logic                last,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                pix_plot
);

    localparam logic [4:0] OX_LAST = 5'(SPR_W - 1);
    localparam logic [3:0] OY_LAST = 4'(SPR_H - 1);
    // One guard bit beyond the position width so base + offset never wraps
    // back onto the screen before the bounds check.
    localparam logic signed [XW+1:0] X_LIM = (XW+2)'(SCREEN_W);
    localparam logic signed [YW+1:0] Y_LIM = (YW+2)'(SCREEN_H);

    logic [4:0]          ox_q;
    logic [3:0]          oy_q;
    logic [CW-1:0]       chan_q;
    logic                clear_q;
    logic signed [XW:0]  bx_q;
    logic signed [YW:0]  by_q;
    logic signed [XW+1:0] px;
    logic signed [YW+1:0] py;
    logic                on_screen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ox_q    <= '0;
            oy_q    <= '0;
            chan_q  <= '0;
            clear_q <= 1'b0;
            bx_q    <= '0;
            by_q    <= '0;
        end else if (start) begin
            ox_q    <= '0;
            oy_q    <= '0;
            chan_q  <= chan;
            clear_q <= is_clear;
            bx_q    <= base_x;
            by_q    <= base_y;
        end else if (active) begin
            if (ox_q == OX_LAST) begin
                ox_q <= '0;
                oy_q <= (oy_q == OY_LAST) ? 4'd0 : oy_q + 4'd1;
            end else begin
                ox_q <= ox_q + 5'd1;
            end
        end
    end

    assign lut_chan = chan_q;
    assign lut_ox   = ox_q;
    assign lut_oy   = oy_q;
    assign last     = active && (ox_q == OX_LAST) && (oy_q == OY_LAST);

    assign px        = (XW+2)'(bx_q) + $signed((XW+2)'(ox_q));
    assign py        = (YW+2)'(by_q) + $signed((YW+2)'(oy_q));
    assign on_screen = (px >= 0) && (px < X_LIM) && (py >= 0) && (py < Y_LIM);

    // Colour lookup is combinational from the address, so the pixel is
    // registered here and appears one cycle after its address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_plot   <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
        end else begin
            pix_plot <= active && on_screen && (clear_q || !lut_transparent);
            if (active) begin
                pix_x      <= px[XW-1:0];
                pix_y      <= py[YW-1:0];
                pix_colour <= clear_q ? BG_COLOUR : lut_colour;
            end
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite position and raster engine for the VGA game path.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only when idle)
//   cmd_chan, cmd_op             target sprite, MOVE/DRAW/CLEAR/HOME
//   cmd_dx, cmd_dy, cmd_free     signed step and clamp/free mode for MOVE
//   lut_chan/ox/oy               colour lookup address
//   lut_colour/lut_transparent   combinational lookup result
//   pix_x/y/colour/pix_plot      pixel write to the VGA adapter
//   done                         one-cycle pulse when a command completes
//   exited                       sticky per-sprite "left screen" flags
//   pos_x, pos_y                 flattened signed sprite positions
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int NUM_SPR  = 2,
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int SPR_W    = 15,
    parameter int SPR_H    = 10,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int STEP_W   = 4,
    parameter int COLOUR_W = 24,
    parameter int HOME_X   = 80,
    parameter int HOME_Y   = 60,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(BLACK),
    localparam int CW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CW-1:0]               cmd_chan,
    input  logic [1:0]                  cmd_op,
    input  logic [STEP_W-1:0]           cmd_dx,
    input  logic [STEP_W-1:0]           cmd_dy,
    input  logic                        cmd_free,
    output logic [CW-1:0]               lut_chan,
    output logic [4:0]                  lut_ox,
    output logic [3:0]                  lut_oy,
    input  logic [COLOUR_W-1:0]         lut_colour,
    input  logic                        lut_transparent,
    output logic [XW-1:0]               pix_x,
    output logic [YW-1:0]               pix_y,
    output logic [COLOUR_W-1:0]         pix_colour,
    output logic                        pix_plot,
    output logic                        done,
    output logic [NUM_SPR-1:0]          exited,
    output logic [NUM_SPR*(XW+1)-1:0]   pos_x,
    output logic [NUM_SPR*(YW+1)-1:0]   pos_y
);

    localparam logic signed [XW:0] MAX_X  = (XW+1)'(SCREEN_W - SPR_W);
    localparam logic signed [YW:0] MAX_Y  = (YW+1)'(SCREEN_H - SPR_H);
    localparam logic signed [XW:0] X_GONE = (XW+1)'(-SPR_W);
    localparam logic signed [YW:0] Y_GONE = (YW+1)'(-SPR_H);
    localparam logic signed [XW:0] X_END  = (XW+1)'(SCREEN_W);
    localparam logic signed [YW:0] Y_END  = (YW+1)'(SCREEN_H);
    localparam logic signed [XW:0] HOME_XS = (XW+1)'(HOME_X);
    localparam logic signed [YW:0] HOME_YS = (YW+1)'(HOME_Y);

    state_e state_q, state_d;
    op_e    op_in, op_q;
    logic   accept, raster_last;

    logic [CW-1:0]            chan_q;
    logic signed [STEP_W-1:0] dx_q, dy_q;
    logic                     free_q;

    logic signed [XW:0] pos_x_q [NUM_SPR];
    logic signed [YW:0] pos_y_q [NUM_SPR];
    logic [NUM_SPR-1:0] exited_q;

    logic signed [XW:0] cur_x, sum_x, new_x;
    logic signed [YW:0] cur_y, sum_y, new_y;
    logic               off_screen, new_exit;

    assign op_in  = op_e'(cmd_op);
    assign accept = cmd_valid && (state_q == ST_IDLE);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MOVE;
            chan_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            free_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_in;
                chan_q <= cmd_chan;
                dx_q   <= cmd_dx;
                dy_q   <= cmd_dy;
                free_q <= cmd_free;
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (op_in == OP_MOVE || op_in == OP_HOME) ? ST_MOVE : ST_RASTER;
                end
            end
            ST_MOVE:   state_d = ST_IDLE;
            ST_RASTER: if (raster_last) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_MOVE) || (state_q == ST_FLUSH);

    // Position update for the latched channel, evaluated during MOVE.
    always_comb begin
        cur_x      = pos_x_q[chan_q];
        cur_y      = pos_y_q[chan_q];
        sum_x      = cur_x + (XW+1)'(dx_q);
        sum_y      = cur_y + (YW+1)'(dy_q);
        off_screen = (sum_x <= X_GONE) || (sum_x >= X_END) ||
                     (sum_y <= Y_GONE) || (sum_y >= Y_END);
        new_x      = sum_x;
        new_y      = sum_y;
        new_exit   = exited_q[chan_q];
        if (op_q == OP_HOME) begin
            new_x    = HOME_XS;
            new_y    = HOME_YS;
            new_exit = 1'b0;
        end else if (free_q) begin
            if (off_screen) begin
                new_x    = HOME_XS;
                new_y    = HOME_YS;
                new_exit = 1'b1;
            end
        end else begin
            if (sum_x < 0)          new_x = '0;
            else if (sum_x > MAX_X) new_x = MAX_X;
            if (sum_y < 0)          new_y = '0;
            else if (sum_y > MAX_Y) new_y = MAX_Y;
        end
    end

    // NOTE: the position table is a handful of flops whose reset value is
    // architecturally visible (home), so it is reset like any other state;
    // a true RAM would not be.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pos_x_q[i] <= HOME_XS;
                pos_y_q[i] <= HOME_YS;
            end
            exited_q <= '0;
        end else if (state_q == ST_MOVE) begin
            pos_x_q[chan_q]  <= new_x;
            pos_y_q[chan_q]  <= new_y;
            exited_q[chan_q] <= new_exit;
        end
    end

    assign exited = exited_q;

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_pos
        assign pos_x[g*(XW+1) +: XW+1] = pos_x_q[g];
        assign pos_y[g*(YW+1) +: YW+1] = pos_y_q[g];
    end

    // Position is snapshotted by the walker on acceptance; it cannot change
    // while the raster runs because no other command is accepted meanwhile.
    sprite_raster_walker #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .XW        (XW),
        .YW        (YW),
        .CW        (CW),
        .COLOUR_W  (COLOUR_W),
        .BG_COLOUR (BG_COLOUR)
    ) u_walker (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (accept && (op_in == OP_DRAW || op_in == OP_CLEAR)),
        .active          (state_q == ST_RASTER),
        .is_clear        (op_in == OP_CLEAR),
        .chan            (cmd_chan),
        .base_x          (pos_x_q[cmd_chan]),
        .base_y          (pos_y_q[cmd_chan]),
        .lut_chan        (lut_chan),
        .lut_ox          (lut_ox),
        .lut_oy          (lut_oy),
        .lut_colour      (lut_colour),
        .lut_transparent (lut_transparent),
        .last            (raster_last),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_colour      (pix_colour),
        .pix_plot        (pix_plot)
    );

endmodule

// File: tb/tb_sprite_engine.sv
// Directed self-checking bench for sprite_engine with default parameters.
// The colour lookup is modelled here: offset ox=0 is transparent and the
// colour encodes {chan, ox, oy} so pixel/address alignment is visible.
module tb_sprite_engine;
    import sprite_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_chan;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_dx, cmd_dy;
    logic        cmd_free;
    logic [0:0]  lut_chan;
    logic [4:0]  lut_ox;
    logic [3:0]  lut_oy;
    logic [23:0] lut_colour;
    logic        lut_transparent;
    logic [7:0]  pix_x;
    logic [6:0]  pix_y;
    logic [23:0] pix_colour;
    logic        pix_plot;
    logic        done;
    logic [1:0]  exited;
    logic [17:0] pos_x;
    logic [15:0] pos_y;

    sprite_engine dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
        .cmd_op(cmd_op), .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_free(cmd_free),
        .lut_chan(lut_chan), .lut_ox(lut_ox), .lut_oy(lut_oy),
        .lut_colour(lut_colour), .lut_transparent(lut_transparent),
        .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_plot(pix_plot),
        .done(done), .exited(exited), .pos_x(pos_x), .pos_y(pos_y)
    );

    always #5 clk = ~clk;

    assign lut_transparent = (lut_ox == 5'd0);
    assign lut_colour      = {7'h2D, lut_chan, 3'b000, lut_ox, 4'h0, lut_oy};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    function automatic logic signed [63:0] get_x(input int ch);
        logic signed [8:0] t;
        t = pos_x[ch*9 +: 9];
        return t;
    endfunction

    function automatic logic signed [63:0] get_y(input int ch);
        logic signed [7:0] t;
        t = pos_y[ch*8 +: 8];
        return t;
    endfunction

    // Results of the most recent run_cmd
    int r_done_cyc, r_done_cnt, r_busy, r_plots, r_colour_err;
    int r_first_x, r_first_y, r_last_x, r_last_y;
    int r_post_ready, r_post_plot;

    // Issue one command and observe until done (bounded). Cycle 0 is the
    // accept cycle; outputs are sampled on falling edges.
    task automatic run_cmd(input int ch, input int op, input int dx, input int dy,
                           input bit free, input int bx, input int by);
        logic [23:0] ec;
        @(negedge clk);
        cmd_chan  = 1'(ch);
        cmd_op    = 2'(op);
        cmd_dx    = 4'(dx);
        cmd_dy    = 4'(dy);
        cmd_free  = free;
        cmd_valid = 1'b1;
        r_done_cyc = 0; r_done_cnt = 0; r_busy = 0; r_plots = 0; r_colour_err = 0;
        r_first_x = -1; r_first_y = -1; r_last_x = -1; r_last_y = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
            if (!cmd_ready) r_busy++;
            if (pix_plot) begin
                r_plots++;
                if (r_first_x < 0) begin
                    r_first_x = int'(pix_x);
                    r_first_y = int'(pix_y);
                end
                r_last_x = int'(pix_x);
                r_last_y = int'(pix_y);
                ec = (op == int'(OP_DRAW)) ?
                     {7'h2D, 1'(ch), 3'b000, 5'(int'(pix_x) - bx), 4'h0, 4'(int'(pix_y) - by)} :
                     24'h000000;
                if (pix_colour !== ec) r_colour_err++;
            end
            if (done) begin
                r_done_cnt++;
                r_done_cyc = c;
                break;
            end
        end
        @(negedge clk);
        r_post_ready = int'(cmd_ready);
        r_post_plot  = int'(pix_plot);
        if (done) r_done_cnt++;
    endtask

    task automatic mv(input int ch, input int dx, input int dy, input bit free);
        run_cmd(ch, int'(OP_MOVE), dx, dy, free, 0, 0);
    endtask

    task automatic home(input int ch);
        run_cmd(ch, int'(OP_HOME), 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done, seen_plot;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_op    = '0;
        cmd_dx    = '0;
        cmd_dy    = '0;
        cmd_free  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_plot", pix_plot, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_colour", pix_colour, 0);
        check("rst_lut_ox", lut_ox, 0);
        check("rst_pos_x0", get_x(0), 80);
        check("rst_pos_y1", get_y(1), 60);
        check("rst_exited", exited, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic clamped MOVE from home
        mv(0, 5, -3, 1'b0);
        check("mv1_x", get_x(0), 85);
        check("mv1_y", get_y(0), 57);
        check("mv1_done_cyc", r_done_cyc, 1);
        check("mv1_done_cnt", r_done_cnt, 1);
        check("mv1_busy", r_busy, 1);
        check("mv1_ready_after", r_post_ready, 1);

        // Clamp edges
        home(0);
        for (int i = 0; i < 8; i++) mv(0, 7, -7, 1'b0);
        mv(0, 7, -3, 1'b0);
        check("clamp_pre_x", get_x(0), 143);
        check("clamp_pre_y", get_y(0), 1);
        mv(0, 7, -4, 1'b0);
        check("clamp_max_x", get_x(0), 145);
        check("clamp_min_y", get_y(0), 0);
        mv(0, -8, -8, 1'b0);
        check("clamp_x_back", get_x(0), 137);
        check("clamp_y_hold", get_y(0), 0);

        // Free-mode exit
        home(0);
        check("home_x", get_x(0), 80);
        check("home_y", get_y(0), 60);
        for (int i = 0; i < 10; i++) mv(0, 7, 0, 1'b1);
        mv(0, 7, 0, 1'b1);
        check("free_157_x", get_x(0), 157);
        check("free_157_exit", exited, 0);
        mv(0, 7, 0, 1'b1);
        check("free_exit_flag", exited, 2'b01);
        check("free_exit_x", get_x(0), 80);
        check("free_exit_y", get_y(0), 60);
        check("chan1_x_untouched", get_x(1), 80);
        home(0);
        check("home_clears_exit", exited, 0);

        // DRAW chan 1 at (80,60), column ox=0 transparent
        run_cmd(1, int'(OP_DRAW), 0, 0, 1'b0, 80, 60);
        check("draw_plots", r_plots, 140);
        check("draw_first_x", r_first_x, 81);
        check("draw_first_y", r_first_y, 60);
        check("draw_last_x", r_last_x, 94);
        check("draw_last_y", r_last_y, 69);
        check("draw_done_cyc", r_done_cyc, 151);
        check("draw_done_cnt", r_done_cnt, 1);
        check("draw_busy", r_busy, 151);
        check("draw_colour_err", r_colour_err, 0);
        check("draw_plot_after", r_post_plot, 0);
        check("draw_ready_after", r_post_ready, 1);

        // Move chan 0 to (150,115) in free mode, then CLEAR with clipping
        for (int i = 0; i < 7; i++) mv(0, 7, 7, 1'b1);
        mv(0, 7, 6, 1'b1);
        mv(0, 7, 0, 1'b1);
        mv(0, 7, 0, 1'b1);
        check("corner_x", get_x(0), 150);
        check("corner_y", get_y(0), 115);
        check("corner_exit", exited, 0);
        run_cmd(0, int'(OP_CLEAR), 0, 0, 1'b0, 150, 115);
        check("clear_plots", r_plots, 50);
        check("clear_colour_err", r_colour_err, 0);
        check("clear_first_x", r_first_x, 150);
        check("clear_first_y", r_first_y, 115);
        check("clear_last_x", r_last_x, 159);
        check("clear_last_y", r_last_y, 119);
        check("clear_done_cyc", r_done_cyc, 151);

        // Reset in the middle of a DRAW (pixel 20 = ox 5, oy 1)
        @(negedge clk);
        cmd_chan  = 1'b1;
        cmd_op    = 2'(OP_DRAW);
        cmd_valid = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) cmd_valid = 1'b0;
        end
        check("mid_plot_before", pix_plot, 1);
        check("mid_pix_x", pix_x, 85);
        check("mid_pix_y", pix_y, 61);
        #1 reset_n = 1'b0;
        #1;
        check("mid_plot_reset", pix_plot, 0);
        check("mid_ready_reset", cmd_ready, 1);
        check("mid_done_reset", done, 0);
        check("mid_pos_x0_home", get_x(0), 80);
        check("mid_pos_y0_home", get_y(0), 60);
        seen_done = 0;
        seen_plot = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (pix_plot) seen_plot++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (pix_plot) seen_plot++;
        end
        check("mid_no_done", seen_done, 0);
        check("mid_no_plot", seen_plot, 0);
        check("mid_ready_idle", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
